// File: rtl/nuc_pkg.sv
// Shared nucleotide definitions for the per-mille estimator and the sampler.
package nuc_pkg;

    typedef logic [1:0] nuc_t;

    localparam nuc_t NUC_A = 2'b00;
    localparam nuc_t NUC_C = 2'b01;
    localparam nuc_t NUC_G = 2'b10;
    localparam nuc_t NUC_T = 2'b11;

    localparam int PROB_SCALE = 1000;
    localparam int PROB_W     = 10;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DIVIDE  = 2'd1,
        ST_PUBLISH = 2'd2
    } est_state_t;

endpackage

// File: rtl/nuc_freq_estimator_seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle.
// A start while idle loads the operands (load cycle); NUM_W step cycles follow.
// done is high during the last step cycle, and quotient/remainder show that
// step's final result combinationally, so a caller can capture it in that cycle.
module seq_udiv #(
    parameter int NUM_W = 20,
    parameter int DEN_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient,
    output logic [DEN_W-1:0] remainder
);

    localparam int STEP_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0]  quo_q, quo_d;
    logic [DEN_W-1:0]  rem_q, rem_d;
    logic [DEN_W-1:0]  den_q, den_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              busy_q, busy_d;
    logic [DEN_W:0]    trial;
    logic [DEN_W:0]    trial_sub;
    logic              fits;

    // Load operands on start, otherwise shift one restoring step per cycle.
    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        den_d     = den_q;
        step_d    = step_q;
        busy_d    = busy_q;
        trial     = {rem_q, quo_q[NUM_W-1]};
        trial_sub = trial - {1'b0, den_q};
        fits      = (trial >= {1'b0, den_q});
        if (busy_q) begin
            quo_d  = {quo_q[NUM_W-2:0], fits};
            rem_d  = fits ? trial_sub[DEN_W-1:0] : trial[DEN_W-1:0];
            step_d = step_q - STEP_W'(1);
            if (step_q == STEP_W'(1)) begin
                busy_d = 1'b0;
            end
        end else if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            den_d  = divisor;
            step_d = STEP_W'(NUM_W);
            busy_d = 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            step_q <= step_d;
            busy_q <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && (step_q == STEP_W'(1));
    assign quotient  = quo_d;
    assign remainder = rem_d;

endmodule

// File: rtl/nuc_freq_estimator.sv
// Windowed A/C/G/T counter producing per-mille probabilities that sum to 1000.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_COLLECT | accept beats, count per nucleotide, wait for window close
//   ST_DIVIDE  | serial divisions for A, C, G; T takes the floor residue
//   ST_PUBLISH | hold estimate with out_valid until out_ready
module nuc_freq_estimator
    import nuc_pkg::*;
#(
    parameter int WINDOW = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_nuc,
    input  logic                         in_last,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PROB_W-1:0]            prob_A,
    output logic [PROB_W-1:0]            prob_C,
    output logic [PROB_W-1:0]            prob_G,
    output logic [PROB_W-1:0]            prob_T,
    output logic [$clog2(WINDOW+1)-1:0]  sample_n
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int NUM_W = CNT_W + PROB_W;

    est_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    logic [CNT_W-1:0]  n_q, n_d;
    logic [1:0]        idx_q, idx_d;
    logic [PROB_W-1:0] q_a_q, q_a_d, q_c_q, q_c_d;
    logic [PROB_W-1:0] prob_q [4];
    logic [PROB_W-1:0] prob_d [4];
    logic [CNT_W-1:0]  sample_n_q, sample_n_d;
    logic              out_valid_q, out_valid_d;

    logic              in_fire;
    logic              div_start, div_busy, div_done;
    logic [NUM_W-1:0]  div_dividend, div_quo;
    logic [CNT_W-1:0]  div_rem;
    logic [PROB_W:0]   prob_t_wide;
    logic              div_unused;

    // cnt * 1000 as 512 + 256 + 128 + 64 + 32 + 8
    function automatic logic [NUM_W-1:0] times_scale(input logic [CNT_W-1:0] c);
        logic [NUM_W-1:0] w;
        w = NUM_W'(c);
        return (w << 9) + (w << 8) + (w << 7) + (w << 6) + (w << 5) + (w << 3);
    endfunction

    assign in_ready     = (state_q == ST_COLLECT);
    assign in_fire      = in_valid && in_ready;
    assign div_start    = (state_q == ST_DIVIDE) && (n_q != '0) && !div_busy;
    assign div_dividend = times_scale(cnt_q[idx_q]);
    assign prob_t_wide  = (PROB_W+1)'(PROB_SCALE)
                        - ((PROB_W+1)'(q_a_q) + (PROB_W+1)'(q_c_q)
                           + (PROB_W+1)'(div_quo[PROB_W-1:0]));
    assign div_unused   = ^{div_rem, div_quo[NUM_W-1:PROB_W], prob_t_wide[PROB_W]};

    seq_udiv #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (n_q),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Next-state, counter, and output-register computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        idx_d       = idx_q;
        q_a_d       = q_a_q;
        q_c_d       = q_c_q;
        prob_d      = prob_q;
        sample_n_d  = sample_n_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_COLLECT: begin
                if (in_fire) begin
                    cnt_d[in_nuc] = cnt_q[in_nuc] + 1'b1;
                    n_d           = n_q + 1'b1;
                end
                if ((in_fire && ((n_d == CNT_W'(WINDOW)) || in_last)) || flush) begin
                    state_d = ST_DIVIDE;
                    idx_d   = 2'd0;
                end
            end
            ST_DIVIDE: begin
                if (n_q == '0) begin
                    for (int i = 0; i < 4; i++) begin
                        prob_d[i] = PROB_W'(PROB_SCALE / 4);
                    end
                    sample_n_d  = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_PUBLISH;
                end else if (div_done) begin
                    if (idx_q == 2'd0) begin
                        q_a_d = div_quo[PROB_W-1:0];
                        idx_d = 2'd1;
                    end else if (idx_q == 2'd1) begin
                        q_c_d = div_quo[PROB_W-1:0];
                        idx_d = 2'd2;
                    end else begin
                        prob_d[0]   = q_a_q;
                        prob_d[1]   = q_c_q;
                        prob_d[2]   = div_quo[PROB_W-1:0];
                        prob_d[3]   = prob_t_wide[PROB_W-1:0];
                        sample_n_d  = n_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_PUBLISH;
                    end
                end
            end
            ST_PUBLISH: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        cnt_d[i] = '0;
                    end
                    n_d     = '0;
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // State and datapath registers; reset discards any in-flight window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_COLLECT;
            n_q         <= '0;
            idx_q       <= '0;
            q_a_q       <= '0;
            q_c_q       <= '0;
            sample_n_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]  <= '0;
                prob_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            q_a_q       <= q_a_d;
            q_c_q       <= q_c_d;
            sample_n_q  <= sample_n_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]  <= cnt_d[i];
                prob_q[i] <= prob_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign prob_A    = prob_q[0];
    assign prob_C    = prob_q[1];
    assign prob_G    = prob_q[2];
    assign prob_T    = prob_q[3];
    assign sample_n  = sample_n_q;

endmodule
